// File: rtl/regfile_arb_pkg.sv
// Shared constants, state encoding and helpers for the register-file arbiter.
package regfile_arb_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 8;
  localparam int RF_DEPTH = 1024;
  localparam int ROW_W    = 5;
  localparam int COL_W    = 5;
  localparam int STAT_W   = 16;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    INIT   = 2'd1,
    RUN    = 2'd2
  } state_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    logic [STAT_W-1:0] result;
    if (value == {STAT_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + {{(STAT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request above the last winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] idx_s;
  logic [PTR_W-1:0] cand_s;
  logic             hit_s;
  logic             found_s;
  logic [N-1:0]     grant_s;

  // Scan from pointer+1 upward with wrap; the first valid request wins.
  always_comb begin
    idx_s   = ptr_r;
    cand_s  = ptr_r;
    hit_s   = 1'b0;
    found_s = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand_s  = PTR_W'((int'(ptr_r) + i) % N);
      hit_s   = !found_s && req[cand_s];
      idx_s   = hit_s ? cand_s : idx_s;
      found_s = found_s | hit_s;
    end
    grant_s        = {N{1'b0}};
    grant_s[idx_s] = found_s;
  end

  // Pointer remembers the last winner; reset value makes requester 0 first.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= PTR_W'(N - 1);
    end else if (advance && found_s) begin
      ptr_r <= idx_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant = grant_s;

endmodule

// File: rtl/regfile_arbiter.sv
// Shares a 1024x8 register file (1W/2R, registered read) among NUM_REQ requesters,
// zero-filling it after reset. Define REGFILE_ARB_STATS_EN for per-requester grant counters.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_a,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_b,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data1,
  output logic [DATA_W-1:0]         rsp_data2,
  output logic                      init_done,
  output logic [ADDR_W-1:0]         rf_wr_addr,
  output logic [ADDR_W-1:0]         rf_rd_addr1,
  output logic [ADDR_W-1:0]         rf_rd_addr2,
  output logic                      rf_wr_enable,
  output logic                      rf_rd_enable,
  output logic [DATA_W-1:0]         rf_in,
  input  logic [DATA_W-1:0]         rf_out1,
  input  logic [DATA_W-1:0]         rf_out2
`ifdef REGFILE_ARB_STATS_EN
  ,
  input  logic                      stat_clear,
  output logic [NUM_REQ*STAT_W-1:0] stat_grant_cnt
`endif
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CNT_W = ROW_W + COL_W;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(RF_DEPTH - 1);

  state_t             state_r;
  state_t             state_s;
  logic [SET_W-1:0]   settle_cnt_r;
  logic [CNT_W-1:0]   init_cnt_r;
  logic               init_done_r;
  logic [NUM_REQ-1:0] rsp_tag_r;

  logic [NUM_REQ-1:0] arb_req_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               granted_s;
  logic               transfer_s;
  logic               sel_we_s;
  logic [ADDR_W-1:0]  sel_addr_a_s;
  logic [ADDR_W-1:0]  sel_addr_b_s;
  logic [DATA_W-1:0]  sel_wdata_s;

  // Next-state: wait for the register file to accept writes, zero-fill it, then serve.
  always_comb begin
    state_s = state_r;
    case (state_r)
      SETTLE: begin
        if (settle_cnt_r == SET_W'(SETTLE_CYCLES - 1)) begin
          state_s = INIT;
        end else begin
          state_s = SETTLE;
        end
      end
      INIT: begin
        if (init_cnt_r == LAST_ADDR) begin
          state_s = RUN;
        end else begin
          state_s = INIT;
        end
      end
      RUN:     state_s = RUN;
      default: state_s = SETTLE;
    endcase
  end

  // State, sequencing counters and the sticky init_done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= SETTLE;
      settle_cnt_r <= {SET_W{1'b0}};
      init_cnt_r   <= {CNT_W{1'b0}};
      init_done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == SETTLE) begin
        settle_cnt_r <= settle_cnt_r + SET_W'(1);
      end
      if (state_r == INIT) begin
        init_cnt_r <= init_cnt_r + CNT_W'(1);
      end
      if ((state_r == INIT) && (init_cnt_r == LAST_ADDR)) begin
        init_done_r <= 1'b1;
      end
    end
  end

  assign arb_req_s  = (state_r == RUN) ? req_valid : {NUM_REQ{1'b0}};
  assign transfer_s = |(req_valid & grant_s);
  assign granted_s  = |grant_s;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req_s),
    .advance (transfer_s),
    .grant   (grant_s)
  );

  // AND-OR mux of the granted request; all zero when nobody is granted.
  always_comb begin
    sel_we_s     = 1'b0;
    sel_addr_a_s = {ADDR_W{1'b0}};
    sel_addr_b_s = {ADDR_W{1'b0}};
    sel_wdata_s  = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_we_s     = sel_we_s | (grant_s[i] & req_we[i]);
      sel_addr_a_s = sel_addr_a_s | ({ADDR_W{grant_s[i]}} & req_addr_a[i*ADDR_W +: ADDR_W]);
      sel_addr_b_s = sel_addr_b_s | ({ADDR_W{grant_s[i]}} & req_addr_b[i*ADDR_W +: ADDR_W]);
      sel_wdata_s  = sel_wdata_s | ({DATA_W{grant_s[i]}} & req_wdata[i*DATA_W +: DATA_W]);
    end
  end

  // Register-file drive: zero-fill writes in INIT, granted operation in RUN.
  always_comb begin
    rf_wr_enable = 1'b0;
    rf_rd_enable = 1'b0;
    rf_wr_addr   = {ADDR_W{1'b0}};
    rf_rd_addr1  = {ADDR_W{1'b0}};
    rf_rd_addr2  = {ADDR_W{1'b0}};
    rf_in        = {DATA_W{1'b0}};
    case (state_r)
      INIT: begin
        rf_wr_enable = 1'b1;
        rf_wr_addr   = init_cnt_r;
      end
      RUN: begin
        if (granted_s && sel_we_s) begin
          rf_wr_enable = 1'b1;
          rf_wr_addr   = sel_addr_a_s;
          rf_in        = sel_wdata_s;
        end else if (granted_s) begin
          rf_rd_enable = 1'b1;
          rf_rd_addr1  = sel_addr_a_s;
          rf_rd_addr2  = sel_addr_b_s;
        end else begin
          rf_rd_enable = 1'b0;
        end
      end
      default: rf_wr_enable = 1'b0;
    endcase
  end

  // One-hot tag of the read granted this cycle; it aligns with the registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_tag_r <= {NUM_REQ{1'b0}};
    end else begin
      rsp_tag_r <= grant_s & ~req_we;
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = rsp_tag_r;
  assign rsp_data1 = (|rsp_tag_r) ? rf_out1 : {DATA_W{1'b0}};
  assign rsp_data2 = (|rsp_tag_r) ? rf_out2 : {DATA_W{1'b0}};
  assign init_done = init_done_r;

`ifdef REGFILE_ARB_STATS_EN
  logic [STAT_W-1:0] stat_r [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    // Saturating grant counter; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
      if (reset || stat_clear) begin
        stat_r[g] <= {STAT_W{1'b0}};
      end else if (req_valid[g] && grant_s[g]) begin
        stat_r[g] <= sat_inc(stat_r[g]);
      end else begin
        stat_r[g] <= stat_r[g];
      end
    end
    assign stat_grant_cnt[g*STAT_W +: STAT_W] = stat_r[g];
  end
`endif

endmodule
